tour_cmd_seq: RTL and testbench

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

---
 rtl/knight_cmd_pkg.sv | 30 +++
 rtl/seq_cmd_mem.sv | 51 +++++
 rtl/tour_cmd_seq.sv | 188 ++++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knight_cmd_pkg.sv
// ---------------------------------------------------------------------------
// knight_cmd_pkg
// Shared constants for the knight command sequencer: command opcodes, the
// positive-acknowledge response byte, fault cause codes and the playback
// state enumeration used by tour_cmd_seq.
// ---------------------------------------------------------------------------
package knight_cmd_pkg;

    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  MOVE     = 4'h4;
    localparam logic [3:0]  TOUR     = 4'h6;

    localparam logic [7:0]  POS_ACK  = 8'hA5;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_BAD_RESP = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        NEXT,
        DONE,
        ERR
    } seq_state_e;

endpackage

// File: rtl/seq_cmd_mem.sv
// ---------------------------------------------------------------------------
// seq_cmd_mem
// DEPTH x 16 command store. Synchronous write, registered read.
// The storage array is never reset; only the read register is, so the
// command word presented to the link is zero out of reset.
//
// Ports
//   clk, rst_n       system clock, async active-low reset (read reg only)
//   wr_en_i          write strobe
//   wr_addr_i        write address
//   wr_data_i        write data
//   rd_en_i          capture mem[rd_addr_i] into the read register
//   rd_addr_i        read address
//   rd_data_o        registered read data
// ---------------------------------------------------------------------------
module seq_cmd_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [15:0]   wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [15:0]   rd_data_o
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register only updates on request, so a later write to the same
    // entry cannot disturb a word that has already been loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 16'h0000;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tour_cmd_seq.sv
// ---------------------------------------------------------------------------
// tour_cmd_seq
// Plays a stored list of 16-bit commands to RemoteComm_e one at a time,
// waiting for transmit-complete and a response byte for each. A response
// other than POS_ACK latches a fault. Optional watchdog (build macro
// SEQ_WATCHDOG_EN) faults a command that takes TMO_CLKS clocks.
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   wr_en, wr_addr, wr_data     command memory write port
//   num_cmds                    entries to play (saturates at DEPTH), sampled on start
//   start                       single-cycle playback start
//   cmd, send_cmd               command word and one-cycle send strobe
//   cmd_sent, resp_rdy, resp    link handshake and response byte
//   busy, done, err             playback active / completed / fault latched
//   idx, err_code               current/faulting entry, fault cause
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// LOAD      | reading mem[idx] onto cmd
// SEND      | send_cmd strobe
// WAIT_SENT | waiting for cmd_sent (a coincident response is accepted)
// WAIT_RESP | waiting for resp_rdy
// NEXT      | advance idx or finish
// DONE      | tour complete, done held until next start
// ERR       | fault latched, err/idx/err_code held until next start
// ---------------------------------------------------------------------------
module tour_cmd_seq
    import knight_cmd_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TMO_CLKS = 4000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [15:0]              wr_data,
    input  logic [$clog2(DEPTH):0]   num_cmds,
    input  logic                     start,
    output logic [15:0]              cmd,
    output logic                     send_cmd,
    input  logic                     cmd_sent,
    input  logic                     resp_rdy,
    input  logic [7:0]               resp,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic [1:0]               err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    seq_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          rd_en;
    logic [CW-1:0] num_sat;
    logic          waiting;
    logic          last_entry;
    logic          resp_fire;
    logic          wdog_tc;

    seq_cmd_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (idx_q),
        .rd_data_o (cmd)
    );

    assign num_sat    = (num_cmds > DEPTH_C) ? DEPTH_C : num_cmds;
    assign waiting    = (state_q == WAIT_SENT) || (state_q == WAIT_RESP);
    assign last_entry = ({1'b0, idx_q} == (cnt_q - CW'(1)));
    // A response is only meaningful once the command has left; in WAIT_SENT
    // that means it must coincide with cmd_sent.
    assign resp_fire  = resp_rdy &&
                        (((state_q == WAIT_SENT) && cmd_sent) || (state_q == WAIT_RESP));

`ifdef SEQ_WATCHDOG_EN
    // Down-counter reloaded while in SEND; the load value makes err visible
    // TMO_CLKS clocks after the send_cmd cycle.
    localparam logic [31:0] WDOG_LOAD = 32'(TMO_CLKS - 2);
    logic [31:0] wdog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == SEND) begin
            wdog_q <= WDOG_LOAD;
        end else if (waiting && (wdog_q != '0)) begin
            wdog_q <= wdog_q - 32'd1;
        end
    end

    assign wdog_tc = waiting && (wdog_q == '0);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CLKS;
    assign wdog_tc    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        err_code_d = err_code_q;
        rd_en      = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    idx_d      = '0;
                    err_code_d = ERR_NONE;
                    if (num_cmds == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = num_sat;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                rd_en   = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                state_d = WAIT_SENT;
            end
            WAIT_SENT, WAIT_RESP: begin
                if (resp_fire) begin
                    if (resp == POS_ACK) begin
                        state_d = NEXT;
                    end else begin
                        state_d    = ERR;
                        err_code_d = ERR_BAD_RESP;
                    end
                end else if ((state_q == WAIT_SENT) && cmd_sent) begin
                    state_d = WAIT_RESP;
                end else if (wdog_tc) begin
                    state_d    = ERR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            NEXT: begin
                if (last_entry) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign send_cmd = (state_q == SEND);
    assign busy     = (state_q == LOAD) || (state_q == SEND) || waiting ||
                      (state_q == NEXT);
    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign idx      = idx_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
module tb_tour_cmd_seq;
    import knight_cmd_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int TMO   = 1000;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [CW-1:0] num_cmds;
    logic          start;
    logic [15:0]   cmd;
    logic          send_cmd;
    logic          cmd_sent;
    logic          resp_rdy;
    logic [7:0]    resp;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] idx;
    logic [1:0]    err_code;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tour_cmd_seq #(.DEPTH(DEPTH), .TMO_CLKS(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .num_cmds (num_cmds),
        .start    (start),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .idx      (idx),
        .err_code (err_code)
    );

    // mode: 0 cmd_sent then response two cycles later, 1 cmd_sent and
    // response in the same cycle, 2 link silent, 3 cmd_sent only
    typedef struct {
        int               n;
        logic [3:0][15:0] cmds;
        int               bad_at;
        logic [7:0]       bad_val;
        int               mode;
        logic             e_done;
        logic             e_err;
        logic [1:0]       e_code;
        int               e_idx;
        int               e_sends;
    } vec_t;

    vec_t        vecs [7];
    int          vec_cnt  = 0;
    int          miss_cnt = 0;
    int          sends    = 0;
    logic [15:0] exp_q  [$];
    int          mode_q [$];
    logic [7:0]  resp_q [$];
    logic [15:0] img    [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // scoreboard: every send_cmd strobe pops the next expected command word
    always @(negedge clk) begin
        if (rst_n && send_cmd) begin
            sends++;
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_send: got send_cmd with cmd %04h, required no send", cmd);
            end else begin
                check("cmd", 32'(cmd), 32'(exp_q.pop_front()));
            end
        end
    end

    // RemoteComm_e model
    initial begin
        int         m;
        logic [7:0] r;
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && send_cmd) begin
                m = (mode_q.size() != 0) ? mode_q.pop_front() : 0;
                r = (resp_q.size() != 0) ? resp_q.pop_front() : POS_ACK;
                if (m != 2) begin
                    @(negedge clk);
                    cmd_sent = 1'b1;
                    resp_rdy = (m == 1);
                    resp     = r;
                    @(negedge clk);
                    cmd_sent = 1'b0;
                    resp_rdy = 1'b0;
                    if (m == 0) begin
                        repeat (2) @(negedge clk);
                        resp_rdy = 1'b1;
                        resp     = r;
                        @(negedge clk);
                        resp_rdy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic mem_write(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start(input int n, output logic d1);
        @(negedge clk);
        num_cmds = CW'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        d1       = done;
    endtask

    task automatic wait_end(input string name);
        for (int c = 0; c < 3000; c++) begin
            if (done || err) return;
            @(negedge clk);
        end
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: timeout with done=%0b err=%0b busy=%0b, required done or err", name, done, err, busy);
    endtask

    task automatic wait_sends(input int target, input string name);
        for (int c = 0; c < 3000; c++) begin
            if (sends >= target) return;
            @(negedge clk);
        end
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: timeout with %0d sends, required %0d", name, sends, target);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_cmd"},      32'(cmd),      32'h0);
        check({p, "_send_cmd"}, 32'(send_cmd), 32'h0);
        check({p, "_busy"},     32'(busy),     32'h0);
        check({p, "_done"},     32'(done),     32'h0);
        check({p, "_err"},      32'(err),      32'h0);
        check({p, "_idx"},      32'(idx),      32'h0);
        check({p, "_err_code"}, 32'(err_code), 32'h0);
    endtask

    task automatic clear_queues();
        exp_q.delete();
        mode_q.delete();
        resp_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int   n_eff;
        int   base;
        logic d1;
        n_eff = (v.n > DEPTH) ? DEPTH : v.n;
        for (int i = 0; i < n_eff; i++) begin
            img[i] = (i < 4) ? v.cmds[i] : (16'h4000 | 16'(i));
            mem_write(i, img[i]);
        end
        for (int i = 0; i < n_eff; i++) begin
            if (v.bad_at >= 0 && i > v.bad_at) break;
            exp_q.push_back(img[i]);
            mode_q.push_back(v.mode);
            resp_q.push_back((i == v.bad_at) ? v.bad_val : POS_ACK);
        end
        base = sends;
        pulse_start(v.n, d1);
        wait_end($sformatf("v%0d_end", k));
        repeat (6) @(negedge clk);
        check($sformatf("v%0d_done_next", k), 32'(d1),           32'(v.n == 0));
        check($sformatf("v%0d_done", k),      32'(done),         32'(v.e_done));
        check($sformatf("v%0d_err", k),       32'(err),          32'(v.e_err));
        check($sformatf("v%0d_err_code", k),  32'(err_code),     32'(v.e_code));
        check($sformatf("v%0d_idx", k),       32'(idx),          32'(v.e_idx));
        check($sformatf("v%0d_busy", k),      32'(busy),         32'h0);
        check($sformatf("v%0d_sends", k),     32'(sends - base), 32'(v.e_sends));
        check($sformatf("v%0d_pending", k),   32'(exp_q.size()), 32'h0);
        clear_queues();
    endtask

    initial begin
        int   base;
        int   lat;
        logic d1;

        rst_n    = 1'b1;
        start    = 1'b0;
        num_cmds = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = 16'h0;

        //          n   cmds[3..0]                                bad val    mode done err code idx sends
        vecs[0] = '{3,  {16'h0000, 16'h4002, 16'h4001, 16'h2000}, -1, 8'h00, 0, 1'b1, 1'b0, 2'b00, 2,  3};
        vecs[1] = '{2,  {16'h0000, 16'h0000, 16'h47F2, 16'h4001},  1, 8'h5A, 0, 1'b0, 1'b1, 2'b01, 1,  2};
        vecs[2] = '{0,  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1, 8'h00, 0, 1'b1, 1'b0, 2'b00, 0,  0};
        vecs[3] = '{4,  {16'h6400, 16'h2000, 16'h4011, 16'h6123}, -1, 8'h00, 1, 1'b1, 1'b0, 2'b00, 3,  4};
        vecs[4] = '{1,  {16'h0000, 16'h0000, 16'h0000, 16'h2000},  0, 8'h00, 0, 1'b0, 1'b1, 2'b01, 0,  1};
        vecs[5] = '{3,  {16'h0000, 16'h4003, 16'h4002, 16'h4001},  2, 8'hA4, 1, 1'b0, 1'b1, 2'b01, 2,  3};
        vecs[6] = '{40, {16'h4F00, 16'h2000, 16'h4004, 16'h6010}, -1, 8'h00, 0, 1'b1, 1'b0, 2'b00, 31, 32};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k], k);
        end

        // extra start while busy, every response coincident with cmd_sent
        img[0] = CAL_GYRO;
        img[1] = 16'h4001;
        img[2] = 16'h4002;
        for (int i = 0; i < 3; i++) begin
            mem_write(i, img[i]);
            exp_q.push_back(img[i]);
            mode_q.push_back(1);
            resp_q.push_back(POS_ACK);
        end
        base = sends;
        pulse_start(3, d1);
        wait_sends(base + 1, "s41_first");
        @(negedge clk);
        num_cmds = CW'(1);
        start    = 1'b1;
        check("s41_busy_at_start", 32'(busy), 32'h1);
        @(negedge clk);
        start    = 1'b0;
        wait_end("s41_end");
        repeat (6) @(negedge clk);
        check("s41_done",    32'(done),          32'h1);
        check("s41_err",     32'(err),           32'h0);
        check("s41_idx",     32'(idx),           32'h2);
        check("s41_sends",   32'(sends - base),  32'h3);
        check("s41_pending", 32'(exp_q.size()),  32'h0);
        clear_queues();

        // reset while waiting for the response to entry 1, with a memory
        // write to the loaded entry in between
        exp_q.push_back(img[0]);
        exp_q.push_back(img[1]);
        mode_q.push_back(0);
        mode_q.push_back(3);
        base = sends;
        pulse_start(3, d1);
        wait_sends(base + 2, "s40_second");
        repeat (4) @(negedge clk);
        check("s40_busy_mid", 32'(busy), 32'h1);
        check("s40_idx_mid",  32'(idx),  32'h1);
        mem_write(1, 16'hBEEF);
        repeat (2) @(negedge clk);
        check("s40_cmd_held", 32'(cmd), 32'h4001);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s40_rst");
        clear_queues();
        repeat (3) @(negedge clk);
        check("s40_no_send_in_rst", 32'(sends - base), 32'h2);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        img[1] = 16'hBEEF;
        for (int i = 0; i < 3; i++) exp_q.push_back(img[i]);
        base = sends;
        pulse_start(3, d1);
        wait_end("s40_replay_end");
        repeat (6) @(negedge clk);
        check("s40_replay_done",    32'(done),         32'h1);
        check("s40_replay_idx",     32'(idx),          32'h2);
        check("s40_replay_sends",   32'(sends - base), 32'h3);
        check("s40_replay_pending", 32'(exp_q.size()), 32'h0);
        clear_queues();

        // link never answers
        exp_q.push_back(img[0]);
        mode_q.push_back(2);
        pulse_start(1, d1);
        for (int c = 0; c < 20; c++) begin
            if (send_cmd) break;
            @(negedge clk);
        end
        check("silent_send_seen", 32'(send_cmd), 32'h1);
`ifdef SEQ_WATCHDOG_EN
        lat = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            lat++;
            if (err) break;
        end
        check("wdog_latency_in_window", 32'((lat >= TMO - 1) && (lat <= TMO + 1)), 32'h1);
        check("wdog_err",      32'(err),      32'h1);
        check("wdog_err_code", 32'(err_code), 32'(ERR_TIMEOUT));
        check("wdog_idx",      32'(idx),      32'h0);
        check("wdog_busy",     32'(busy),     32'h0);
`else
        lat = 0;
        repeat (1500) begin
            @(negedge clk);
            lat++;
        end
        check("nowdog_err",      32'(err),      32'h0);
        check("nowdog_busy",     32'(busy),     32'h1);
        check("nowdog_err_code", 32'(err_code), 32'(ERR_NONE));
`endif
        rst_n = 1'b0;
        clear_queues();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
